// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_arbiter
// Description : Shares one single-port RAM (1-cycle registered read) between
//               a host loader/dumper (port 0) and a sort engine (port 1).
//               Grants are per-owner, with an optional lock that is
//               force-broken after LOCK_MAX owned cycles while the other
//               port waits. Read data returns one cycle later and is tagged
//               with the port that issued the read.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_arbiter #(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_DATA = 8,
  parameter int LOCK_MAX  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0,
  input  logic                 i_we0,
  input  logic                 i_lock0,
  input  logic [SIZE_ADDR-1:0] i_addr0,
  input  logic [SIZE_DATA-1:0] i_wdata0,
  output logic                 o_gnt0,
  output logic                 o_rvalid0,
  input  logic                 i_req1,
  input  logic                 i_we1,
  input  logic                 i_lock1,
  input  logic [SIZE_ADDR-1:0] i_addr1,
  input  logic [SIZE_DATA-1:0] i_wdata1,
  output logic                 o_gnt1,
  output logic                 o_rvalid1,
  output logic [SIZE_DATA-1:0] o_rdata,
  output logic                 o_ram_rd_en,
  output logic                 o_ram_wr_en,
  output logic [SIZE_ADDR-1:0] o_ram_addr,
  output logic [SIZE_DATA-1:0] o_ram_wdata,
  input  logic [SIZE_DATA-1:0] i_ram_rdata,
  output logic                 o_lock_to
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  // Counter value at which a contended lock is broken.
  localparam logic [7:0] c_lock_last = 8'(LOCK_MAX - 1);

  state_t     r_state, w_next;
  logic       r_ptr, w_ptr_next;          // 0: favour port 0 on a tie
  logic [7:0] r_lock_cnt, w_lock_cnt_next;
  logic       r_lock_to, w_lock_to_next;
  logic       r_rd_pend;                  // a read was issued last cycle
  logic       r_rd_port;                  // which port issued it

  logic w_is_own1, w_own_req, w_own_lock, w_oth_req;
  logic w_acc0, w_acc1;

  // Owner-relative views of the request inputs.
  assign w_is_own1  = (r_state == S_OWN1);
  assign w_own_req  = w_is_own1 ? i_req1  : i_req0;
  assign w_own_lock = w_is_own1 ? i_lock1 : i_lock0;
  assign w_oth_req  = w_is_own1 ? i_req0  : i_req1;

  // An access happens only when the owner requests; non-owner waits.
  assign w_acc0 = (r_state == S_OWN0) && i_req0;
  assign w_acc1 = (r_state == S_OWN1) && i_req1;

  assign o_gnt0      = (r_state == S_OWN0);
  assign o_gnt1      = (r_state == S_OWN1);
  assign o_ram_rd_en = (w_acc0 && !i_we0) || (w_acc1 && !i_we1);
  assign o_ram_wr_en = (w_acc0 && i_we0) || (w_acc1 && i_we1);
  assign o_ram_addr  = w_acc0 ? i_addr0 : (w_acc1 ? i_addr1 : '0);
  assign o_ram_wdata = (w_acc0 && i_we0) ? i_wdata0 :
                       ((w_acc1 && i_we1) ? i_wdata1 : '0);

  assign o_rvalid0 = r_rd_pend && !r_rd_port;
  assign o_rvalid1 = r_rd_pend && r_rd_port;
  assign o_rdata   = r_rd_pend ? i_ram_rdata : '0;
  assign o_lock_to = r_lock_to;

  // Next-state, pointer, lock counter and lock-break decision.
  always_comb begin
    w_next          = r_state;
    w_ptr_next      = r_ptr;
    w_lock_cnt_next = r_lock_cnt;
    w_lock_to_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req0 && i_req1) w_next = r_ptr ? S_OWN1 : S_OWN0;
        else if (i_req0)      w_next = S_OWN0;
        else if (i_req1)      w_next = S_OWN1;
      end
      S_OWN0, S_OWN1: begin
        if (w_own_lock) begin
          if (!w_oth_req) begin
            w_lock_cnt_next = 8'd0;
          end else if (r_lock_cnt == c_lock_last) begin
            w_next          = w_is_own1 ? S_OWN0 : S_OWN1;
            w_lock_to_next  = 1'b1;
            w_lock_cnt_next = 8'd0;
          end else if (r_lock_cnt != 8'hFF) begin
            w_lock_cnt_next = r_lock_cnt + 8'd1;
          end
        end else begin
          w_lock_cnt_next = 8'd0;
          if (w_oth_req)       w_next = w_is_own1 ? S_OWN0 : S_OWN1;
          else if (!w_own_req) w_next = S_IDLE;
        end
        // Leaving ownership hands the tie-break to the other port.
        if (w_next != r_state) w_ptr_next = !w_is_own1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, arbitration bookkeeping and read-return tag registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 1'b0;
      r_lock_cnt <= 8'd0;
      r_lock_to  <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_port  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ptr      <= w_ptr_next;
      r_lock_cnt <= w_lock_cnt_next;
      r_lock_to  <= w_lock_to_next;
      r_rd_pend  <= o_ram_rd_en;
      r_rd_port  <= w_acc1;
    end
  end

endmodule
`default_nettype wire
